serial_tx_fifo: RTL and testbench
=================================

// Module: serial_tx_fifo
// PURPOSE
//  Byte FIFO sitting directly upstream of async_transmitter on the TxD path.
//  Producers (echo logic, command responders) push bytes at clock rate.
//  The block drains them one at a time through the transmitter's start/busy
//  handshake, so bursts are never lost while a character is on the wire.
// PARAMETERS
//  DEPTH_LOG2   4   FIFO depth = 2**DEPTH_LOG2 entries (16); legal range 1..8
// PORTS
//  clk         in   1    system clock, all logic on rising edge
//  rst         in   1    synchronous reset, active-high
//  wr_en       in   1    push wr_data this cycle
//  wr_data     in   8    byte to queue
//  full        out  1    FIFO holds 2**DEPTH_LOG2 bytes
//  empty       out  1    FIFO holds 0 bytes
//  level       out  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2
//  overflow    out  1    sticky: a push was dropped; cleared only by rst
//  TxD_start   out  1    one-cycle start pulse to async_transmitter
//  TxD_data    out  8    byte presented to async_transmitter
//  TxD_busy    in   1    async_transmitter busy flag
// BEHAVIOUR
//  Reset (rst=1 at clock edge): level=0, empty=1, full=0, overflow=0,
//   TxD_start=0, TxD_data=8'h00, FSM=IDLE, read/write pointers=0.
//   Reset mid-transmission discards all queued bytes; the byte already in
//   async_transmitter is not recalled.
//  Storage: circular buffer, pointers DEPTH_LOG2 bits, wrap modulo depth.
//   full/empty/level are registered and updated in the same cycle as pointers.
//  Push: if wr_en && !full at the edge, store at wr_ptr, wr_ptr++, level++.
//   If wr_en && full, byte dropped, overflow<=1. Full is evaluated from the
//   state at the start of the cycle; a pop in the same cycle does not make
//   room for that push.
//  Simultaneous push (accepted) and pop: level unchanged, both pointers advance.
//  Drain FSM (all outputs registered):
//   IDLE      : if !empty && !TxD_busy -> TxD_data<=mem[rd_ptr], rd_ptr++,
//               level--, TxD_start<=1, go START.
//   START     : TxD_start<=0; go WAIT_BUSY.
//   WAIT_BUSY : if TxD_busy -> WAIT_DONE; else after 2 cycles in this state
//               without busy -> IDLE (guard against missed busy).
//   WAIT_DONE : when !TxD_busy -> IDLE.
//  TxD_start is high exactly one cycle per byte; TxD_data is held constant
//   from the pop cycle until the next pop.
//  Latency: byte pushed into an empty FIFO with transmitter idle produces
//   TxD_start 2 cycles after the push edge (1 to become non-empty, 1 to pop).
//  Minimum spacing between TxD_start pulses: 4 cycles, in addition to the
//   busy time.
//  Bytes leave in exact push order; no byte is duplicated or skipped except
//   on overflow drop.
// TESTING
//  1 Push 8'h41 once, TxD_busy model 10 cycles -> single TxD_start 2 cycles
//    later with TxD_data=8'h41; level returns to 0, empty=1.
//  2 Push 8'h00..8'h0F back-to-back (DEPTH_LOG2=4), busy 100 cycles -> full=1
//    no earlier than cycle 16; all 16 bytes emitted in order; overflow=0.
//  3 With transmitter held busy, push 17 bytes -> full=1, 17th byte dropped,
//    overflow=1 and stays 1; output sequence 8'h00..8'h0F only.
//  4 Push every cycle while draining, busy 3 cycles -> level never
//    exceeds 16, order preserved across pointer wrap (>=40 bytes total).
//  5 Assert rst while in WAIT_DONE with level=5 -> next cycle level=0,
//    empty=1, overflow=0, TxD_start=0; no further start pulses.
//  6 Transmitter model that never asserts busy -> FSM returns to IDLE
//    2 cycles after START and continues draining; no hang.

Source files
------------

// File: rtl/serial_tx_fifo_if.sv
// Producer push port plus async_transmitter start/busy handshake for serial_tx_fifo.
// Push is fire-and-forget (wr_en qualifies wr_data); TxD_start is a one-cycle strobe answered by TxD_busy.
interface serial_tx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                wr_en;
    logic [7:0]          wr_data;
    logic                full;
    logic                empty;
    logic [DEPTH_LOG2:0] level;
    logic                overflow;
    logic                TxD_start;
    logic [7:0]          TxD_data;
    logic                TxD_busy;

    modport slave (
        input  wr_en, wr_data, TxD_busy,
        output full, empty, level, overflow, TxD_start, TxD_data
    );

    modport master (
        output wr_en, wr_data, TxD_busy,
        input  full, empty, level, overflow, TxD_start, TxD_data
    );
endinterface

// File: rtl/serial_tx_fifo.sv
// Byte FIFO draining into async_transmitter one character at a time via start/busy.
// dbg_state_o encodes the drain FSM: 0=IDLE, 1=START, 2=WAIT_BUSY, 3=WAIT_DONE.
module serial_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic               clk,
    input  logic               rst,
    serial_tx_fifo_if.slave    bus,
    output logic [1:0]         dbg_state_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_e;

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  overflow_q, overflow_d;
    state_e                state_q, state_d;
    logic                  start_q, start_d;
    logic [7:0]            data_q, data_d;
    logic                  wait_q, wait_d;
    logic                  push;
    logic                  pop;

    // Full is taken from the registered flag, so a same-cycle pop never makes room.
    assign push = bus.wr_en && !full_q;

    always_comb begin
        state_d    = state_q;
        start_d    = 1'b0;
        data_d     = data_q;
        wait_d     = wait_q;
        pop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty_q && !bus.TxD_busy) begin
                    pop     = 1'b1;
                    data_d  = mem_q[rd_ptr_q];
                    start_d = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                wait_d  = 1'b0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // Give up after two quiet cycles in case busy was never raised.
                if (bus.TxD_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (wait_q) begin
                    state_d = S_IDLE;
                end else begin
                    wait_d = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!bus.TxD_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
        full_d     = (level_d == FULL_LEVEL);
        empty_d    = (level_d == '0);
        overflow_d = overflow_q | (bus.wr_en & full_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            data_q     <= 8'h00;
            wait_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            start_q    <= start_d;
            data_q     <= data_d;
            wait_q     <= wait_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.full      = full_q;
    assign bus.empty     = empty_q;
    assign bus.level     = level_q;
    assign bus.overflow  = overflow_q;
    assign bus.TxD_start = start_q;
    assign bus.TxD_data  = data_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_serial_tx_fifo.sv
// Directed and randomized checks of serial_tx_fifo against a queue-based reference
// model and a simple async_transmitter busy model.
module tb_serial_tx_fifo;
    localparam int DL    = 4;
    localparam int DEPTH = 1 << DL;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    serial_tx_fifo_if #(.DEPTH_LOG2(DL)) bus();

    serial_tx_fifo #(.DEPTH_LOG2(DL)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q[$];
    logic       exp_ovf = 1'b0;
    int         cyc = 0;
    int         busy_cnt = 0;
    int         busy_len = 10;
    bit         hold_busy = 1'b0;
    bit         start_prev = 1'b0;
    int         last_start = -1;
    bit         strict_gap = 1'b0;
    int         accepted = 0;
    int         n_starts = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance, update transmitter model, score outputs.
    task automatic step(input bit wr, input logic [7:0] d);
        bit acc;
        bus.wr_en   = wr;
        bus.wr_data = d;
        acc = wr && !rst && (exp_q.size() < DEPTH);
        if (wr && !rst && !acc) exp_ovf = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        if (busy_cnt > 0) busy_cnt--;
        if (start_prev) busy_cnt = busy_len;
        start_prev   = bus.TxD_start;
        bus.TxD_busy = hold_busy || (busy_cnt > 0);
        if (rst) begin
            exp_q.delete();
            exp_ovf = 1'b0;
            chk("rst_start", 32'(bus.TxD_start), 32'd0);
            chk("rst_data", 32'(bus.TxD_data), 32'h00);
            chk("rst_state", 32'(dbg_state), 32'd0);
        end else if (bus.TxD_start) begin
            chk("pop_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("tx_byte", 32'(bus.TxD_data), 32'(exp_q.pop_front()));
            if (last_start >= 0) begin
                chk("start_gap_min", 32'((cyc - last_start) >= 4), 32'd1);
                if (strict_gap) chk("start_gap_nobusy", 32'(cyc - last_start), 32'd4);
            end
            last_start = cyc;
            n_starts++;
        end
        if (acc) begin
            exp_q.push_back(d);
            accepted++;
        end
        chk("level", 32'(bus.level), 32'(exp_q.size()));
        chk("empty", 32'(bus.empty), 32'(exp_q.size() == 0));
        chk("full", 32'(bus.full), 32'(exp_q.size() == DEPTH));
        chk("overflow", 32'(bus.overflow), 32'(exp_ovf));
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) step(1'b0, 8'h00);
        repeat (8) step(1'b0, 8'h00);
        chk("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int snap;
        int acc0;
        rst          = 1'b1;
        bus.wr_en    = 1'b0;
        bus.wr_data  = 8'h00;
        bus.TxD_busy = 1'b0;
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        rst = 1'b0;
        step(1'b0, 8'h00);

        // Single byte: start pulse on the second edge after the push.
        busy_len = 10;
        step(1'b1, 8'h41);
        chk("lat_no_start_yet", 32'(bus.TxD_start), 32'd0);
        step(1'b0, 8'h00);
        chk("lat_start", 32'(bus.TxD_start), 32'd1);
        chk("lat_data", 32'(bus.TxD_data), 32'h41);
        step(1'b0, 8'h00);
        chk("start_one_cycle", 32'(bus.TxD_start), 32'd0);
        chk("data_held", 32'(bus.TxD_data), 32'h41);
        drain(40);

        // Back-to-back burst 00..0F with a slow transmitter.
        busy_len = 100;
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i));
        drain(3000);
        chk("burst_no_overflow", 32'(bus.overflow), 32'd0);

        // Transmitter held busy: 17 pushes, last one dropped.
        hold_busy    = 1'b1;
        bus.TxD_busy = 1'b1;
        for (int i = 0; i < 17; i++) step(1'b1, 8'(i));
        chk("hold_full", 32'(bus.full), 32'd1);
        chk("hold_overflow", 32'(bus.overflow), 32'd1);
        hold_busy = 1'b0;
        busy_len  = 10;
        drain(600);
        chk("overflow_sticky", 32'(bus.overflow), 32'd1);

        // Reset while waiting on the transmitter with 5 bytes queued.
        busy_len = 40;
        for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom));
        repeat (3) step(1'b0, 8'h00);
        chk("pre_rst_level", 32'(bus.level), 32'd5);
        chk("pre_rst_wait_done", 32'(dbg_state), 32'd3);
        rst = 1'b1;
        step(1'b0, 8'h00);
        rst = 1'b0;
        chk("post_rst_level", 32'(bus.level), 32'd0);
        chk("post_rst_overflow", 32'(bus.overflow), 32'd0);
        snap = n_starts;
        repeat (60) step(1'b0, 8'h00);
        chk("no_start_after_rst", 32'(n_starts - snap), 32'd0);

        // Continuous pushing while draining; order kept across pointer wrap.
        busy_len = 3;
        acc0 = accepted;
        for (int i = 0; i < 60; i++) step(1'b1, 8'($urandom));
        for (int i = 0; i < 240; i++) step($urandom_range(0, 3) == 0, 8'($urandom));
        drain(800);
        chk("wrap_volume", 32'((accepted - acc0) >= 40), 32'd1);

        // Transmitter never raises busy: timeout path keeps draining every 4 cycles.
        busy_len   = 0;
        strict_gap = 1'b1;
        last_start = -1;
        snap       = n_starts;
        for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom));
        drain(100);
        chk("nobusy_count", 32'(n_starts - snap), 32'd6);
        strict_gap = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
